// File: rtl/ysyx_24070017_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner IDs, word width.
`ifndef ysyx_24070017_WORD_LENGTH
`define ysyx_24070017_WORD_LENGTH 32
`endif

package ysyx_24070017_mem_arbiter_pkg;
  localparam int WORD_LENGTH = `ysyx_24070017_WORD_LENGTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;
endpackage

// File: rtl/ysyx_24070017_Reg.sv
// Generic enabled register with synchronous active-high reset.
module ysyx_24070017_Reg #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);
  always_ff @(posedge clk) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end
endmodule

// File: rtl/ysyx_24070017_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// whoever was not granted last. grant[0]=IFU, grant[1]=LSU.
module ysyx_24070017_rr_arb2
  import ysyx_24070017_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic [1:0] grant
);
  assign grant[0] = req[0] & (~req[1] | (last_grant == OWN_LS));
  assign grant[1] = req[1] & (~req[0] | (last_grant == OWN_IF));
endmodule

// File: rtl/ysyx_24070017_mem_arbiter.sv
// Serialises IFU and LSU requests onto one memory port, one transaction in
// flight, with a watchdog that turns a silent memory into an error response.
module ysyx_24070017_mem_arbiter
  import ysyx_24070017_mem_arbiter_pkg::*;
#(
  parameter int DATA_W  = WORD_LENGTH,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [DATA_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [DATA_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state, state_nx;
  owner_t              owner, last_grant;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [1:0]          grant;
  logic                accept, busy, resp_hit, timeout_hit;

  ysyx_24070017_rr_arb2 u_arb (
    .req        ({ls_req_valid, if_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept      = (state == ST_IDLE) && !rst && (|grant);
  assign busy        = (state == ST_REQ) || (state == ST_WAIT);
  assign resp_hit    = (state == ST_WAIT) && mem_resp_valid;
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt == CNT_W'(TIMEOUT));

  // IFU fetches are forced to reads so a stray LSU store mask never leaks.
  ysyx_24070017_Reg #(.WIDTH(DATA_W)) u_addr (
    .clk(clk), .rst(rst), .wen(accept),
    .din(grant[1] ? ls_addr : if_addr), .dout(mem_addr));
  ysyx_24070017_Reg #(.WIDTH(DATA_W)) u_wdata (
    .clk(clk), .rst(rst), .wen(accept),
    .din(grant[1] ? ls_wdata : '0), .dout(mem_wdata));
  ysyx_24070017_Reg #(.WIDTH(1)) u_wen (
    .clk(clk), .rst(rst), .wen(accept),
    .din(grant[1] & ls_wen), .dout(mem_wen));
  ysyx_24070017_Reg #(.WIDTH(DATA_W/8)) u_wmask (
    .clk(clk), .rst(rst), .wen(accept),
    .din(grant[1] ? ls_wmask : '0), .dout(mem_wmask));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_REQ;
      ST_REQ: begin
        if (timeout_hit)        state_nx = ST_RESP;
        else if (mem_req_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: if (resp_hit || timeout_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_LS;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= grant[1] ? OWN_LS : OWN_IF;
        cnt   <= '0;
      end else if (busy && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
      // A response arriving on the timeout cycle takes priority over the error.
      if (resp_hit) begin
        rdata_q <= mem_wen ? '0 : mem_rdata;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state == ST_RESP) last_grant <= owner;
    end
  end

  assign if_req_ready  = accept && grant[0];
  assign ls_req_ready  = accept && grant[1];
  assign mem_req_valid = (state == ST_REQ);
  assign if_resp_valid = (state == ST_RESP) && (owner == OWN_IF);
  assign ls_resp_valid = (state == ST_RESP) && (owner == OWN_LS);
  assign if_resp_err   = if_resp_valid && err_q;
  assign ls_resp_err   = ls_resp_valid && err_q;
  assign if_rdata      = rdata_q;
  assign ls_rdata      = rdata_q;
endmodule

// File: tb/tb_ysyx_24070017_mem_arbiter.sv
// Directed bench: a vector table of single transactions plus hand sequences
// for store stall, timeout, response/timeout race and mid-transaction reset.
module tb_ysyx_24070017_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  ysyx_24070017_mem_arbiter #(.DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifv, lsv;
    logic [31:0] ia, la;
    logic        lw;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] mrd;
    logic        win;      // 0 = IFU, 1 = LSU
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wm;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  // Accept at T, mem ready at T+1, mem response at T+2, pulse at T+3.
  task automatic run_vec(input vec_t v, input int i);
    @(posedge clk); #1;
    if_req_valid = v.ifv; if_addr = v.ia;
    ls_req_valid = v.lsv; ls_addr = v.la; ls_wen = v.lw; ls_wdata = v.wd; ls_wmask = v.wm;
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), {62'd0, ls_req_ready, if_req_ready},
        {62'd0, v.win, ~v.win});
    @(posedge clk); #1;
    idle_inputs();
    mem_req_ready = 1;
    @(negedge clk);
    chk($sformatf("v%0d_mem_req", i), {58'd0, mem_req_valid, mem_wen, mem_wmask},
        {58'd0, 1'b1, v.e_wen, v.e_wm});
    chk($sformatf("v%0d_mem_addr", i), {32'd0, mem_addr}, {32'd0, v.e_addr});
    @(posedge clk); #1;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = v.mrd;
    @(negedge clk);
    chk($sformatf("v%0d_no_early", i), {62'd0, ls_resp_valid, if_resp_valid}, 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 0; mem_rdata = 0;
    @(negedge clk);
    chk($sformatf("v%0d_resp", i), {60'd0, ls_resp_valid, if_resp_valid, ls_resp_err, if_resp_err},
        {60'd0, v.win, ~v.win, 2'b00});
    chk($sformatf("v%0d_rdata", i), {32'd0, (v.win ? ls_rdata : if_rdata)}, {32'd0, v.e_rdata});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    //            ifv lsv ia            la            lw wd            wm    mrd           win e_addr        wen wm    e_rdata
    vecs[0] = '{1, 1, 32'h80000000, 32'h80002000, 1, 32'h11111111, 4'hf, 32'h00100073, 0, 32'h80000000, 0, 4'h0, 32'h00100073};
    vecs[1] = '{1, 1, 32'h80000004, 32'h80002004, 0, 32'h00000000, 4'h0, 32'hAABBCCDD, 1, 32'h80002004, 0, 4'h0, 32'hAABBCCDD};
    vecs[2] = '{1, 1, 32'h80000008, 32'h80002008, 1, 32'h22222222, 4'hf, 32'h55AA55AA, 0, 32'h80000008, 0, 4'h0, 32'h55AA55AA};
    vecs[3] = '{1, 0, 32'h80000000, 32'h00000000, 0, 32'h00000000, 4'h0, 32'h00100073, 0, 32'h80000000, 0, 4'h0, 32'h00100073};
    vecs[4] = '{0, 1, 32'h00000000, 32'h80000100, 0, 32'h00000000, 4'h0, 32'h0BADF00D, 1, 32'h80000100, 0, 4'h0, 32'h0BADF00D};
    vecs[5] = '{0, 1, 32'h00000000, 32'h80000200, 1, 32'h01020304, 4'hc, 32'hFFFFFFFF, 1, 32'h80000200, 1, 4'hc, 32'h00000000};
    vecs[6] = '{1, 1, 32'h8000000C, 32'h80003000, 0, 32'h00000000, 4'h0, 32'h13579BDF, 0, 32'h8000000C, 0, 4'h0, 32'h13579BDF};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {56'd0, if_req_ready, if_resp_valid, if_resp_err, ls_req_ready,
                     ls_resp_valid, ls_resp_err, mem_req_valid, mem_wen}, 64'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
    chk("rst_wmask", {60'd0, mem_wmask}, 64'd0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // LSU store held off by memory for 5 cycles; inputs scrambled after accept.
    @(posedge clk); #1;
    ls_req_valid = 1; ls_addr = 32'h80001000; ls_wen = 1; ls_wdata = 32'hDEADBEEF; ls_wmask = 4'h3;
    @(negedge clk);
    chk("st_ready", {63'd0, ls_req_ready}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    ls_addr = 32'h12341234; ls_wdata = 32'h55555555; ls_wmask = 4'hf;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("st_hold%0d_ctl", c), {58'd0, mem_req_valid, mem_wen, mem_wmask},
          {58'd0, 1'b1, 1'b1, 4'h3});
      chk($sformatf("st_hold%0d_dat", c), {mem_addr, mem_wdata}, {32'h80001000, 32'hDEADBEEF});
      @(posedge clk); #1;
    end
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    chk("st_resp", {61'd0, ls_resp_valid, ls_resp_err, if_resp_valid}, {61'd0, 3'b100});
    chk("st_rdata", {32'd0, ls_rdata}, 64'd0);

    // Timeout: memory never accepts; error pulse TIMEOUT+1 = 9 cycles after REQ.
    @(posedge clk); #1;
    ls_req_valid = 1; ls_addr = 32'h80004000;
    @(negedge clk);
    chk("to_ready", {63'd0, ls_req_ready}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (ls_resp_valid) break;
      @(posedge clk); #1;
      k++;
    end
    chk("to_latency", 64'(k), 64'd9);
    chk("to_resp", {61'd0, ls_resp_err, if_resp_valid, mem_req_valid}, {61'd0, 3'b100});
    chk("to_rdata", {32'd0, ls_rdata}, 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1; mem_rdata = 32'hDEADDEAD;
    @(negedge clk);
    chk("to_one_pulse", {62'd0, ls_resp_valid, if_resp_valid}, 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("to_late%0d", c), {61'd0, ls_resp_valid, if_resp_valid, mem_req_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // Response on the exact cycle the counter reaches TIMEOUT wins.
    if_req_valid = 1; if_addr = 32'h80000010;
    @(negedge clk);
    chk("race_ready", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    repeat (7) @(posedge clk);
    #1;
    mem_resp_valid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("race_no_early", {63'd0, if_resp_valid}, 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 0; mem_rdata = 0;
    @(negedge clk);
    chk("race_resp", {62'd0, if_resp_valid, if_resp_err}, {62'd0, 2'b10});
    chk("race_rdata", {32'd0, if_rdata}, {32'd0, 32'h12345678});

    // Reset while in WAIT aborts; a new request is accepted right after.
    @(posedge clk); #1;
    ls_req_valid = 1; ls_addr = 32'h80005000;
    @(posedge clk); #1;
    idle_inputs();
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 32'h0BADBEEF;
    if_req_valid = 1; if_addr = 32'h80000040;
    @(negedge clk);
    chk("rstw_ctrl", {58'd0, if_resp_valid, ls_resp_valid, ls_req_ready, mem_req_valid, mem_wen, ls_resp_err},
        64'd0);
    chk("rstw_mem", {mem_addr, ls_rdata}, 64'd0);
    chk("rstw_accept", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    mem_req_ready = 1;
    @(negedge clk);
    chk("rstw_addr", {31'd0, mem_req_valid, mem_addr}, {31'd0, 1'b1, 32'h80000040});
    chk("rstw_no_ls", {63'd0, ls_resp_valid}, 64'd0);
    @(posedge clk); #1;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h00000013;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(negedge clk);
    chk("rstw_resp", {61'd0, if_resp_valid, ls_resp_valid, if_resp_err}, {61'd0, 3'b100});
    chk("rstw_rdata", {32'd0, if_rdata}, 64'h13);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
